alu_arbiter: RTL

- Shares the single combinational ALU between two requesters, e.g. the main datapath port (0) and an address/branch helper port (1).
- Arbitrates with round-robin priority, registers the granted operands and drives them to the shared ALU.
- Captures the ALU result and returns it to the winner over a valid/ready handshake.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_arbiter_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 19 +
 rtl/alu_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: select codes, the
// legal select ceiling and the arbiter FSM encoding.
package alu_arbiter_pkg;

  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_SUB  = 4'd1;
  localparam logic [3:0] SEL_XOR  = 4'd2;
  localparam logic [3:0] SEL_OR   = 4'd3;
  localparam logic [3:0] SEL_AND  = 4'd4;
  localparam logic [3:0] SEL_SLL  = 4'd5;
  localparam logic [3:0] SEL_SRL  = 4'd6;
  localparam logic [3:0] SEL_SRA  = 4'd7;
  localparam logic [3:0] SEL_SLT  = 4'd8;
  localparam logic [3:0] SEL_SLTU = 4'd9;
  localparam logic [3:0] SEL_LUI  = 4'd10;

  localparam int unsigned ALU_SEL_MAX = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Codes above the ceiling have no ALU meaning and are reported as errors.
  function automatic logic sel_illegal(input logic [3:0] sel, input int unsigned sel_max);
    return 32'(sel) > sel_max;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone request always wins, and on
// contention the port named by ptr wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin grant,
// registered operands to the ALU, and a held result with valid/ready return.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int          width   = 32,
  parameter int unsigned SEL_MAX = ALU_SEL_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [width-1:0] req0_rs1,
  input  logic [width-1:0] req0_rs2,
  input  logic [3:0]       req0_sel,
  input  logic [width-1:0] req1_rs1,
  input  logic [width-1:0] req1_rs2,
  input  logic [3:0]       req1_sel,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [width-1:0] rsp_rd,
  output logic             rsp_err,
  output logic [width-1:0] alu_rs1,
  output logic [width-1:0] alu_rs2,
  output logic [3:0]       alu_sel,
  input  logic [width-1:0] alu_rd
);

  state_t           state;
  state_t           state_next;
  logic             rr_ptr;
  logic             owner;
  logic [1:0]       grant;
  logic             accept;
  logic             winner;
  logic [width-1:0] grant_rs1;
  logic [width-1:0] grant_rs2;
  logic [3:0]       grant_sel;

  rr_arb2 u_rr_arb2 (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Grant is only offered in IDLE; held low during reset so nothing looks accepted.
  assign req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign winner    = grant[1];

  always_comb begin
    grant_rs1 = req0_rs1;
    grant_rs2 = req0_rs2;
    grant_sel = req0_sel;
    if (winner) begin
      grant_rs1 = req1_rs1;
      grant_rs2 = req1_rs2;
      grant_sel = req1_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready[owner]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // alu_* is deliberately left holding its last operands between operations.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      alu_rs1   <= '0;
      alu_rs2   <= '0;
      alu_sel   <= 4'd0;
      rsp_valid <= 2'b00;
      rsp_rd    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner   <= winner;
            rr_ptr  <= ~winner;
            alu_rs1 <= grant_rs1;
            alu_rs2 <= grant_rs2;
            alu_sel <= grant_sel;
          end
        end
        EXEC: begin
          rsp_rd    <= sel_illegal(alu_sel, SEL_MAX) ? '0 : alu_rd;
          rsp_err   <= sel_illegal(alu_sel, SEL_MAX);
          rsp_valid <= owner ? 2'b10 : 2'b01;
        end
        RESP: begin
          if (rsp_ready[owner]) rsp_valid <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  a_req_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_rsp_valid_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));

endmodule
